// File: rtl/lcd_capture_v2.sv
// RGB LCD capture front-end: measures and locks the input resolution, then streams pixels
// plus burst-aligning pad words into the SDRAM write FIFO. Crop window: define LCD_CAP_CROP_EN.
module lcd_capture_v2 #(
  parameter int          CNT_W       = 12,
  parameter bit          OUT_565     = 1'b1,
  parameter bit          VS_POL      = 1'b1,
  parameter bit          HS_POL      = 1'b1,
  parameter int          BURST_PIX   = 256,
  parameter int          LOCK_FRAMES = 2,
  parameter logic [23:0] PAD_VALUE   = '0,
  localparam int         OUT_W       = OUT_565 ? 16 : 24
) (
  input  logic             lcd_pclk_i,
  input  logic             rst_n,
  input  logic             lcd_vs_i,
  input  logic             lcd_hs_i,
  input  logic             lcd_de_i,
  input  logic [23:0]      lcd_rgb_i,
  input  logic             fifo_full_i,
`ifdef LCD_CAP_CROP_EN
  input  logic [CNT_W-1:0] crop_x0,
  input  logic [CNT_W-1:0] crop_y0,
  input  logic [CNT_W-1:0] crop_w,
  input  logic [CNT_W-1:0] crop_h,
`endif
  output logic             write_req,
  output logic [OUT_W-1:0] write_data,
  output logic             fifo_clr,
  output logic [CNT_W-1:0] h_disp,
  output logic [CNT_W-1:0] v_disp,
  output logic             init_done,
  output logic             frame_err,
  output logic             overflow
);
  localparam int         BL     = $clog2(BURST_PIX);
  localparam logic [2:0] LOCK_N = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {S_WAIT_VS, S_ACTIVE, S_PAD, S_VBLANK} state_t;
  state_t r_state, w_nxt;

  logic               r_vs, r_vs_q, r_hs, r_de, r_de_q;
  logic [23:0]        r_rgb;
  logic               r_in_frame, r_cap, r_bad;
  logic [CNT_W-1:0]   r_hcnt, r_vcnt, r_line_len, r_prev_h, r_prev_v;
  logic [2*CNT_W-1:0] r_pix_cnt;
  logic [BL-1:0]      r_pad_left, w_pad_n;
  logic [2:0]         r_lock, w_lock_nxt;
  logic               w_frame_start, w_frame_end, w_de_rise, w_de_fall, w_pad_abort;
  logic               w_meas_bad, w_meas_chg, w_meas_same, w_in_crop, w_last_line;
  logic [OUT_W-1:0]   w_pix;
  logic [7:0]         w_rgb_unused;
  logic               w_unused;

  always_ff @(posedge lcd_pclk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_vs   <= ~VS_POL;
      r_vs_q <= ~VS_POL;
      r_hs   <= ~HS_POL;
      r_de   <= 1'b0;
      r_de_q <= 1'b0;
      r_rgb  <= '0;
    end else begin
      r_vs   <= lcd_vs_i;
      r_vs_q <= r_vs;
      r_hs   <= lcd_hs_i;
      r_de   <= lcd_de_i;
      r_de_q <= r_de;
      r_rgb  <= lcd_rgb_i;
    end
  end

  generate
    if (OUT_565) begin : g_565
      assign w_pix        = {r_rgb[23:19], r_rgb[15:10], r_rgb[7:3]};
      assign w_rgb_unused = {r_rgb[18:16], r_rgb[9:8], r_rgb[2:0]};
    end else begin : g_888
      assign w_pix        = r_rgb;
      assign w_rgb_unused = '0;
    end
  endgenerate

  // Line timing comes entirely from DE; HS is sampled but carries no extra information.
  assign w_unused = &{1'b0, r_hs ^ HS_POL, w_rgb_unused};

  assign w_frame_start = (r_vs_q == VS_POL) && (r_vs != VS_POL);
  assign w_frame_end   = (r_vs_q != VS_POL) && (r_vs == VS_POL);
  assign w_de_rise     = r_de & ~r_de_q;
  assign w_de_fall     = ~r_de & r_de_q;
  assign fifo_clr      = w_frame_start;
  assign w_pad_n       = -r_pix_cnt[BL-1:0];

`ifdef LCD_CAP_CROP_EN
  logic [CNT_W-1:0] r_cx0, r_cy0, r_cw, r_ch, w_x, w_y;
  logic [CNT_W:0]   w_x_end, w_y_end;
  logic             w_crop_on;

  always_ff @(posedge lcd_pclk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_cx0 <= '0;
      r_cy0 <= '0;
      r_cw  <= '0;
      r_ch  <= '0;
    end else if (w_frame_start) begin
      r_cx0 <= crop_x0;
      r_cy0 <= crop_y0;
      r_cw  <= crop_w;
      r_ch  <= crop_h;
    end
  end

  // Pixel coordinates of the current de_r cycle; counters update one edge behind.
  assign w_crop_on   = (r_cw != '0) && (r_ch != '0);
  assign w_x         = w_de_rise ? '0 : r_hcnt;
  assign w_y         = w_de_rise ? r_vcnt : r_vcnt - CNT_W'(1);
  assign w_x_end     = {1'b0, r_cx0} + {1'b0, r_cw};
  assign w_y_end     = {1'b0, r_cy0} + {1'b0, r_ch};
  assign w_in_crop   = !w_crop_on || (w_x >= r_cx0 && {1'b0, w_x} < w_x_end &&
                                      w_y >= r_cy0 && {1'b0, w_y} < w_y_end);
  assign w_last_line = w_crop_on ? ({1'b0, r_vcnt} == w_y_end) : (r_vcnt == v_disp);
`else
  assign w_in_crop   = 1'b1;
  assign w_last_line = (r_vcnt == v_disp);
`endif

  assign w_meas_bad  = r_bad || (r_line_len == '0) || (r_vcnt == '0);
  assign w_meas_chg  = init_done && ((r_line_len != h_disp) || (r_vcnt != v_disp));
  assign w_meas_same = (r_lock != 3'd0) && (r_line_len == r_prev_h) && (r_vcnt == r_prev_v);
  assign w_lock_nxt  = !w_meas_same ? 3'd1 : (r_lock >= LOCK_N) ? LOCK_N : r_lock + 3'd1;

  always_comb begin
    w_nxt       = r_state;
    write_req   = 1'b0;
    write_data  = w_pix;
    w_pad_abort = 1'b0;
    case (r_state)
      S_ACTIVE: begin
        write_req = r_cap & r_de & w_in_crop;
        if (r_cap && w_de_fall && w_last_line)
          w_nxt = (w_pad_n == '0) ? S_VBLANK : S_PAD;
      end
      S_PAD: begin
        write_req  = 1'b1;
        write_data = PAD_VALUE[OUT_W-1:0];
        if (r_pad_left == BL'(1)) w_nxt = S_VBLANK;
      end
      default: ;
    endcase
    if (w_frame_end || w_frame_start) begin
      w_nxt       = w_frame_end ? S_VBLANK : S_ACTIVE;
      w_pad_abort = (r_state == S_PAD);
      if (r_state == S_PAD) write_req = 1'b0;
    end
  end

  always_ff @(posedge lcd_pclk_i or negedge rst_n) begin
    if (!rst_n) r_state <= S_WAIT_VS;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge lcd_pclk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_in_frame <= 1'b0;
      r_cap      <= 1'b0;
      r_bad      <= 1'b0;
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_line_len <= '0;
      r_pix_cnt  <= '0;
      r_pad_left <= '0;
    end else begin
      if (w_frame_start) begin
        r_in_frame <= 1'b1;
        r_cap      <= init_done | (r_lock == LOCK_N);
        r_bad      <= 1'b0;
        r_hcnt     <= '0;
        r_vcnt     <= '0;
        r_line_len <= '0;
        r_pix_cnt  <= '0;
      end else begin
        if (w_frame_end) begin
          r_in_frame <= 1'b0;
          r_cap      <= 1'b0;
        end else if (r_in_frame) begin
          if (w_de_rise) begin
            r_hcnt <= CNT_W'(1);
            r_vcnt <= r_vcnt + CNT_W'(1);
          end else if (r_de) begin
            r_hcnt <= r_hcnt + CNT_W'(1);
          end
          if (w_de_fall) begin
            if (r_vcnt == CNT_W'(1)) r_line_len <= r_hcnt;
            else if (r_hcnt != r_line_len) r_bad <= 1'b1;
          end
        end
        if (write_req) r_pix_cnt <= r_pix_cnt + (2*CNT_W)'(1);
      end
      if (r_state == S_ACTIVE && w_nxt == S_PAD) r_pad_left <= w_pad_n;
      else if (r_state == S_PAD)                 r_pad_left <= r_pad_left - BL'(1);
    end
  end

  // Lock tracking: measurements are only judged for frames whose start was seen.
  always_ff @(posedge lcd_pclk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_lock    <= 3'd0;
      r_prev_h  <= '0;
      r_prev_v  <= '0;
      h_disp    <= '0;
      v_disp    <= '0;
      init_done <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= w_pad_abort;
      if (w_frame_end && r_in_frame) begin
        if (w_meas_bad) begin
          frame_err <= 1'b1;
          r_lock    <= 3'd0;
        end else if (w_meas_chg) begin
          frame_err <= 1'b1;
          init_done <= 1'b0;
          r_lock    <= 3'd1;
          r_prev_h  <= r_line_len;
          r_prev_v  <= r_vcnt;
        end else begin
          r_lock   <= w_lock_nxt;
          r_prev_h <= r_line_len;
          r_prev_v <= r_vcnt;
          if (w_lock_nxt == LOCK_N) begin
            h_disp <= r_line_len;
            v_disp <= r_vcnt;
          end
        end
      end
      if (w_frame_start && r_lock == LOCK_N) init_done <= 1'b1;
      if (write_req && fifo_full_i) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_capture_v2.sv
// Frame-level bench for lcd_capture_v2: random pixels, directed resolutions, checked by a lock/capture model.
module tb_lcd_capture_v2;
  localparam int          CNT_W = 12;
  localparam int          BURST = 16;
  localparam int          LF    = 2;
  localparam logic [23:0] PADV  = 24'h00A5C3;
  localparam logic [15:0] PAD16 = 16'hA5C3;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             vs = 1'b0, hs = 1'b0, de = 1'b0, full = 1'b0;
  logic [23:0]      rgb = '0;
  logic             write_req, fifo_clr, init_done, frame_err, overflow;
  logic [15:0]      write_data;
  logic [CNT_W-1:0] h_disp, v_disp;

  always #5 clk = ~clk;

  lcd_capture_v2 #(
    .CNT_W(CNT_W), .OUT_565(1'b1), .VS_POL(1'b1), .HS_POL(1'b1),
    .BURST_PIX(BURST), .LOCK_FRAMES(LF), .PAD_VALUE(PADV)
  ) dut (
    .lcd_pclk_i(clk), .rst_n(rst_n), .lcd_vs_i(vs), .lcd_hs_i(hs), .lcd_de_i(de),
    .lcd_rgb_i(rgb), .fifo_full_i(full), .write_req(write_req), .write_data(write_data),
    .fifo_clr(fifo_clr), .h_disp(h_disp), .v_disp(v_disp), .init_done(init_done),
    .frame_err(frame_err), .overflow(overflow)
  );

  int          n_vec = 0, n_bad = 0;
  int          m_lock = 0, m_h = 0, m_v = 0, m_ph = 0, m_pv = 0;
  bit          m_init = 0, m_ovf = 0;
  logic [15:0] exp_q[$], got_q[$];
  int          err_cnt = 0, clr_cnt = 0, idx = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (write_req) got_q.push_back(write_data);
      if (frame_err) err_cnt++;
      if (fifo_clr)  clr_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to565(input logic [23:0] c);
    int v;
    v = int'(c);
    return 16'((((v >> 19) & 31) << 11) | (((v >> 10) & 63) << 5) | ((v >> 3) & 31));
  endfunction

  task automatic check_words();
    chk("word_count", got_q.size(), exp_q.size());
    while (idx < got_q.size() && idx < exp_q.size()) begin
      chk("word", got_q[idx], exp_q[idx]);
      idx++;
    end
  endtask

  // One frame: start (VS leaves active), nl lines of w0 pixels, tail, then VS pulse (end).
  task automatic frame(input int w0, input int nl, input int badline, input bit f_full);
    bit cap, bad, exp_err;
    int wr, pad, eb, cb, len;
    logic [23:0] px;
    eb = err_cnt;
    cb = clr_cnt;
    if (m_lock == LF) m_init = 1;
    cap = m_init;
    wr  = 0;
    vs = 1'b0; full = f_full;
    repeat (3) tick();
    for (int l = 0; l < nl; l++) begin
      len = (l == badline) ? w0 - 1 : w0;
      for (int p = 0; p < len; p++) begin
        px = 24'($urandom);
        de = 1'b1; rgb = px;
        if (cap && l < m_v) begin
          exp_q.push_back(to565(px));
          wr++;
        end
        tick();
      end
      de = 1'b0; tick();
      hs = 1'b1; tick();
      hs = 1'b0; repeat (2) tick();
    end
    pad = (cap && nl >= m_v) ? (BURST - wr % BURST) % BURST : 0;
    repeat (pad) exp_q.push_back(PAD16);
    if (f_full && (wr + pad) > 0) m_ovf = 1;
    repeat (20) tick();
    full = 1'b0;
    vs = 1'b1; tick(); tick(); #1;
    bad     = (nl == 0) || (badline >= 0 && badline < nl && nl > 1);
    exp_err = 0;
    if (bad) begin
      exp_err = 1;
      m_lock  = 0;
    end else if (m_init && (w0 != m_h || nl != m_v)) begin
      exp_err = 1;
      m_init  = 0;
      m_lock  = 1;
      m_ph = w0; m_pv = nl;
    end else begin
      if (m_lock != 0 && w0 == m_ph && nl == m_pv) m_lock = (m_lock >= LF) ? LF : m_lock + 1;
      else m_lock = 1;
      m_ph = w0; m_pv = nl;
      if (m_lock == LF) begin
        m_h = w0; m_v = nl;
      end
    end
    chk("frame_err", err_cnt - eb, exp_err);
    chk("fifo_clr", clr_cnt - cb, 1);
    chk("h_disp", h_disp, m_h);
    chk("v_disp", v_disp, m_v);
    chk("init_done", init_done, m_init);
    chk("overflow", overflow, m_ovf);
    check_words();
  endtask

  initial begin
    int w, h;
    logic [23:0] px;
    rst_n = 1'b0;
    repeat (3) tick(); #1;
    chk("rst_write_req", write_req, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_fifo_clr", fifo_clr, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_h_disp", h_disp, 0);
    chk("rst_v_disp", v_disp, 0);
    rst_n = 1'b1;
    vs = 1'b1; repeat (3) tick();

    frame(8, 4, 2, 1'b0);                  // 7-pixel line: bad frame
    frame(8, 4, -1, 1'b1);                 // unlocked, FIFO full but nothing written
    frame(8, 4, -1, 1'b0);                 // second identical frame: lock
    frame(8, 4, -1, 1'b0);                 // captured, 32 words, no pad
    frame(8, 4, -1, 1'b0);
    repeat (3) frame(8, 5, -1, 1'b0);      // change, relock, then 40 + 8 pad
    repeat (3) frame(10, 3, -1, 1'b0);     // change, relock, then 30 + 2 pad
    frame(10, 3, -1, 1'b1);                // overflow while capturing
    frame(10, 3, -1, 1'b0);                // overflow stays set
    for (int r = 0; r < 4; r++) begin
      w = $urandom_range(3, 12);
      h = $urandom_range(2, 5);
      for (int k = 0; k < 3; k++)
        frame(w, h, ($urandom_range(0, 5) == 0) ? 1 : -1, 1'b0);
    end
    repeat (3) frame(8, 4, -1, 1'b0);      // ensure a lock at 8x4

    // Reset in the middle of a captured line.
    if (m_lock == LF) m_init = 1;
    vs = 1'b0; repeat (3) tick();
    for (int p = 0; p < 3; p++) begin
      px = 24'($urandom);
      de = 1'b1; rgb = px;
      if (m_init) exp_q.push_back(to565(px));
      tick();
    end
    #1 chk("pre_rst_write_req", write_req, m_init);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_write_req", write_req, 0);
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_h_disp", h_disp, 0);
    check_words();
    m_lock = 0; m_init = 0; m_h = 0; m_v = 0; m_ovf = 0;
    de = 1'b0; vs = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    repeat (3) frame(8, 4, -1, 1'b0);      // fresh relock after reset

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/lcd_capture_v2.md
Name: lcd_capture_v2

Overview:
Parametrised RGB LCD input capture front-end: measures incoming active resolution, locks after stable frames and streams pixels into the SDRAM write FIFO. Pads each frame up to a burst multiple with a fixed pad value. Adds sync polarity selection, RGB565/RGB888 output, resolution-change detection and overflow flagging. Sits between the LCD input pins and the SDRAM write FIFO in the lcd_pclk_i domain.

Parameters:
CNT_W, 12, width of h/v counters and measured resolution
OUT_565, 1, 1: write_data = {R[7:3],G[7:2],B[7:3]} (OUT_W=16); 0: raw 24-bit (OUT_W=24)
VS_POL, 1, active level of lcd_vs_i
HS_POL, 1, active level of lcd_hs_i
BURST_PIX, 256, words per SDRAM burst; power of two, 2..4096
LOCK_FRAMES, 2, consecutive identical measurements required for lock (1..7)
PAD_VALUE, 0, value written for pad words (OUT_W bits)

Ports:
lcd_pclk_i  in  1  pixel clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
lcd_vs_i  in  1  vertical sync
lcd_hs_i  in  1  horizontal sync
lcd_de_i  in  1  data enable
lcd_rgb_i  in  24  {R,G,B} 8 bits each
fifo_full_i  in  1  write FIFO full
write_req  out  1  write strobe, one word per cycle
write_data  out  OUT_W  pixel or pad word
fifo_clr  out  1  one-cycle FIFO clear pulse
h_disp  out  CNT_W  locked active pixels per line
v_disp  out  CNT_W  locked active lines per frame
init_done  out  1  resolution locked, capture enabled
frame_err  out  1  one-cycle pulse on abnormal frame
overflow  out  1  sticky: write_req issued while fifo_full_i high

Behaviour:
- Reset: all outputs 0; state S_WAIT_VS; counters, lock count 0.
- Inputs registered once (vs_r, hs_r, de_r, rgb_r); edges from vs_r/hs_r vs previous copy.
- frame_start = vs leaves VS_POL level; frame_end = vs enters VS_POL level.
- fifo_clr: pulse exactly on frame_start cycle, regardless of lock.
- States: S_WAIT_VS -> (frame_start) S_ACTIVE -> (last line DE fall, locked) S_PAD -> (pad done) S_VBLANK -> (frame_start) S_ACTIVE. frame_end in any state -> S_VBLANK.
- Measurement in S_ACTIVE: hcnt counts de_r cycles per line; first line's count is line_len; any later nonzero line count != line_len marks frame bad. vcnt counts DE rising edges. At frame_end, (line_len, vcnt) is the frame measurement; zero or bad -> frame_err pulse, lock count 0.
- Lock: equal to previous good measurement -> lock count +1 (saturate at LOCK_FRAMES), else lock count 1. When lock count reaches LOCK_FRAMES, h_disp/v_disp load on that frame_end; init_done sets on next frame_start.
- Resolution change while locked: measurement != (h_disp,v_disp) -> init_done clears same cycle, frame_err pulse, lock count 1; h_disp/v_disp hold until relock.
- Capture: only frames starting with init_done=1. write_req = de_r while S_ACTIVE; latency 1 cycle from lcd_de_i to write_req. pix_cnt (width 2*CNT_W) counts words written.
- Pad: entered cycle after DE fall when vcnt == v_disp; pad words = (BURST_PIX - pix_cnt[log2 BURST_PIX-1:0]) mod BURST_PIX, one per cycle, write_data = PAD_VALUE; zero pads -> straight to S_VBLANK.
- frame_end or frame_start during S_PAD: pad aborted, frame_err pulse.
- DE in S_VBLANK/S_WAIT_VS ignored, no write.
- overflow: set when write_req & fifo_full_i; clears only on reset. No backpressure; writes are never stalled.
- Reset mid-frame: immediate return to reset values; next capture needs full relock.

Optional Feature:
LCD_CAP_CROP_EN: adds inputs crop_x0, crop_y0, crop_w, crop_h (CNT_W each), sampled at frame_start. Only pixels with x0<=hcnt<x0+w and y0<=line<y0+h are written; pad based on cropped count; pad starts after DE fall of line y0+h-1. w or h zero -> full frame. Measurement/lock unaffected. Without macro: ports absent, full frame always written.

Test Plan:
- BURST_PIX=16, LOCK_FRAMES=2, 8x4 frames x4 -> init_done after frame 2 end + next frame_start; frames 3,4 write 32 words each, no pad; h_disp=8, v_disp=4.
- 10x3 frames, BURST_PIX=16 -> 30 pixel writes then 2 PAD_VALUE words per locked frame.
- Locked at 8x4, then one 8x5 frame -> frame_err pulse, init_done clears, no writes until two 8x5 frames relock (v_disp=5).
- Line of 7 pixels inside 8-wide frame -> frame_err, lock count 0, that frame's h_disp unchanged.
- fifo_full_i high during a pixel write -> overflow=1 sticky until rst_n.
- rst_n low mid-line -> write_req=0, init_done=0 immediately; relock needs LOCK_FRAMES fresh frames.
